// File: rtl/intra_pkg.sv
// Shared types, constants and z-scan helpers for the intra TU walkers.
package intra_pkg;

  typedef enum logic [1:0] {IDLE, WAIT_CFG, EMIT} state_t;

  localparam int unsigned TU_LOG2_MIN = 2;
  localparam int unsigned TU_LOG2_MAX = 5;
  localparam int unsigned CTB_UNITS   = 256;

  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
  } tu_pos_t;

  // Even z-index bits carry x, odd bits carry y (4-sample units inside the CTB).
  function automatic tu_pos_t zscan_pos(input logic [7:0] zi);
    tu_pos_t p;
    for (int unsigned b = 0; b < 4; b++) begin
      p.x[b] = zi[2*b];
      p.y[b] = zi[2*b+1];
    end
    return p;
  endfunction

  function automatic logic [2:0] clamp_log2(input logic [2:0] v);
    if (v < 3'(TU_LOG2_MIN)) return 3'(TU_LOG2_MIN);
    if (v > 3'(TU_LOG2_MAX)) return 3'(TU_LOG2_MAX);
    return v;
  endfunction

endpackage

// File: rtl/intra_tu_walker_if.sv
// Per-CTB configuration and TU descriptor handshakes of the intra TU walker.
interface intra_tu_walker_if;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [2:0] cfg_tuSize;
  logic       tu_valid;
  logic       tu_ready;
  logic [8:0] xCtb;
  logic [8:0] yCtb;
  logic [3:0] xTb_rela;
  logic [3:0] yTb_rela;
  logic [2:0] tuSize;
  logic       tu_last_ctb;
  logic       tu_last_pic;

  modport master (
    input  cfg_valid, cfg_tuSize, tu_ready,
    output cfg_ready, tu_valid, xCtb, yCtb, xTb_rela, yTb_rela, tuSize,
           tu_last_ctb, tu_last_pic
  );

  modport slave (
    output cfg_valid, cfg_tuSize, tu_ready,
    input  cfg_ready, tu_valid, xCtb, yCtb, xTb_rela, yTb_rela, tuSize,
           tu_last_ctb, tu_last_pic
  );
endinterface

// File: rtl/intra_zscan_ctr.sv
// Z-index counter over the 256 4x4 units of a CTB with TU-size dependent step.
module intra_zscan_ctr (
  input  logic       clk,
  input  logic       arst_n,
  input  logic       clr,
  input  logic       adv,
  input  logic [2:0] tu_log2,
  output logic [7:0] zi,
  output logic       wrap
);

  logic [7:0] step;
  logic [8:0] sum;

  always_comb begin
    step = 8'd1;
    case (tu_log2)
      3'd3:    step = 8'd4;
      3'd4:    step = 8'd16;
      3'd5:    step = 8'd64;
      default: step = 8'd1;
    endcase
  end

  assign sum  = {1'b0, zi} + {1'b0, step};
  assign wrap = sum[8];

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n)  zi <= '0;
    else if (clr) zi <= '0;
    else if (adv) zi <= sum[7:0];
  end

endmodule

// File: rtl/intra_tu_walker.sv
// Walks CTBs in raster order and TUs in z-scan order, emitting TU descriptors.
// Optional INTRA_TUWALK_CLIP_EN skips TUs lying outside pic_w_min/pic_h_min.
module intra_tu_walker
  import intra_pkg::*;
#(
  parameter int unsigned PIC_CTB_W = 7
) (
  input  logic                 clk,
  input  logic                 arst_n,
  input  logic                 start,
  input  logic [PIC_CTB_W-1:0] pic_w_ctb,
  input  logic [PIC_CTB_W-1:0] pic_h_ctb,
`ifdef INTRA_TUWALK_CLIP_EN
  input  logic [10:0]          pic_w_min,
  input  logic [10:0]          pic_h_min,
`endif
  output logic                 done,
  intra_tu_walker_if.master    bus
);

  state_t               state;
  logic [PIC_CTB_W-1:0] col, row, w_last, h_last;
  logic [2:0]           tu_size;
  logic [7:0]           zi;
  logic                 zi_wrap, zi_clr, zi_adv;
  logic                 emit, emit_ok, last_ctb, last_pic, xfer;
  tu_pos_t              pos;

  assign pos  = zscan_pos(zi);
  assign emit = (state == EMIT);

`ifdef INTRA_TUWALK_CLIP_EN
  logic [11:0] w_min, h_min, abs_x, abs_y, units;

  always_comb begin
    units = 12'd1;
    case (tu_size)
      3'd3:    units = 12'd2;
      3'd4:    units = 12'd4;
      3'd5:    units = 12'd8;
      default: units = 12'd1;
    endcase
  end

  assign abs_x   = 12'({col, 4'b0000}) + 12'(pos.x);
  assign abs_y   = 12'({row, 4'b0000}) + 12'(pos.y);
  assign emit_ok = (abs_x < w_min) && (abs_y < h_min);
  // Morton order is monotone per axis, so the last kept TU is the one whose
  // right and lower neighbours both fall outside the CTB or the picture.
  assign last_ctb = ((12'(pos.x) + units >= 12'd16) || (abs_x + units >= w_min)) &&
                    ((12'(pos.y) + units >= 12'd16) || (abs_y + units >= h_min));

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      w_min <= '0;
      h_min <= '0;
    end else if (state == IDLE && start) begin
      w_min <= {1'b0, pic_w_min};
      h_min <= {1'b0, pic_h_min};
    end
  end
`else
  assign emit_ok  = 1'b1;
  assign last_ctb = zi_wrap;
`endif

  assign last_pic = last_ctb && (col == w_last) && (row == h_last);
  assign xfer     = bus.tu_valid && bus.tu_ready;
  assign zi_clr   = xfer && last_ctb;
  assign zi_adv   = emit && (xfer || !emit_ok);

  intra_zscan_ctr u_zscan (
    .clk     (clk),
    .arst_n  (arst_n),
    .clr     (zi_clr),
    .adv     (zi_adv),
    .tu_log2 (tu_size),
    .zi      (zi),
    .wrap    (zi_wrap)
  );

  assign bus.cfg_ready   = (state == WAIT_CFG);
  assign bus.tu_valid    = emit && emit_ok;
  assign bus.xCtb        = 9'({col, 2'b00});
  assign bus.yCtb        = 9'({row, 2'b00});
  assign bus.xTb_rela    = pos.x;
  assign bus.yTb_rela    = pos.y;
  assign bus.tuSize      = tu_size;
  assign bus.tu_last_ctb = bus.tu_valid && last_ctb;
  assign bus.tu_last_pic = bus.tu_valid && last_pic;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state   <= IDLE;
      col     <= '0;
      row     <= '0;
      w_last  <= '0;
      h_last  <= '0;
      tu_size <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          w_last <= (pic_w_ctb == '0) ? '0 : pic_w_ctb - 1'b1;
          h_last <= (pic_h_ctb == '0) ? '0 : pic_h_ctb - 1'b1;
          col    <= '0;
          row    <= '0;
          state  <= WAIT_CFG;
        end
        WAIT_CFG: if (bus.cfg_valid) begin
          tu_size <= clamp_log2(bus.cfg_tuSize);
          state   <= EMIT;
        end
        EMIT: if (xfer && last_ctb) begin
          if (last_pic) begin
            col   <= '0;
            row   <= '0;
            done  <= 1'b1;
            state <= IDLE;
          end else begin
            if (col == w_last) begin
              col <= '0;
              row <= row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
            state <= WAIT_CFG;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_intra_tu_walker.sv
// Table-driven bench for intra_tu_walker plus hand-written reset sequence.
module tb_intra_tu_walker;

  logic       clk = 1'b0;
  logic       arst_n = 1'b0;
  logic       start = 1'b0;
  logic [6:0] pic_w_ctb = '0;
  logic [6:0] pic_h_ctb = '0;
  logic       done;

  intra_tu_walker_if bus();

  intra_tu_walker #(.PIC_CTB_W(7)) dut (
    .clk       (clk),
    .arst_n    (arst_n),
    .start     (start),
    .pic_w_ctb (pic_w_ctb),
    .pic_h_ctb (pic_h_ctb),
`ifdef INTRA_TUWALK_CLIP_EN
    .pic_w_min (11'h7FF),
    .pic_h_min (11'h7FF),
`endif
    .done      (done),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int unsigned errors = 0;
  int unsigned checks = 0;

  typedef struct packed {
    logic [6:0]      w;
    logic [6:0]      h;
    logic [2:0]      ncfg;
    logic [3:0][2:0] sz;
    logic [3:0][2:0] l2;
    logic [15:0]     total;
    logic            stall;
    logic            poke;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] out_word();
    return {bus.xCtb, bus.yCtb, bus.xTb_rela, bus.yTb_rela, bus.tuSize,
            bus.tu_last_ctb, bus.tu_last_pic, bus.tu_valid};
  endfunction

  task automatic run_pic(input vec_t v);
    int unsigned w_eff, h_eff, nctb, got, n, idx, cyc, l2;
    logic [7:0]  zi;
    logic [3:0]  xr, yr;
    logic [31:0] cur, snap, exp;
    bit          stalled, rdy, lc, lp;
    w_eff = (v.w == 0) ? 1 : int'(v.w);
    h_eff = (v.h == 0) ? 1 : int'(v.h);
    nctb  = w_eff * h_eff;
    got   = 0;
    pic_w_ctb = v.w;
    pic_h_ctb = v.h;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int unsigned k = 0; k < nctb; k++) begin
      l2 = int'(v.l2[k % v.ncfg]);
      n  = 256 >> (2 * (l2 - 2));
      chk("cfg_ready_wait", 64'(bus.cfg_ready), 64'd1);
      chk("bubble_valid", 64'(bus.tu_valid), 64'd0);
      bus.cfg_valid  = 1'b1;
      bus.cfg_tuSize = v.sz[k % v.ncfg];
      @(negedge clk);
      bus.cfg_valid = 1'b0;
      idx = 0; cyc = 0; stalled = 0; snap = '0;
      while (idx < n && cyc < 4 * n + 16) begin
        cur = out_word();
        if (stalled) chk("stall_hold", 64'(cur), 64'(snap));
        if (!bus.tu_valid) begin
          chk("valid_gap", 64'(bus.tu_valid), 64'd1);
          stalled = 0;
        end else begin
          zi = 8'(idx << (2 * (l2 - 2)));
          for (int unsigned b = 0; b < 4; b++) begin
            xr[b] = zi[2*b];
            yr[b] = zi[2*b+1];
          end
          lc  = (idx == n - 1);
          lp  = lc && (k == nctb - 1);
          exp = {9'((k % w_eff) * 4), 9'((k / w_eff) * 4), xr, yr, 3'(l2), lc, lp, 1'b1};
          chk("tu_desc", 64'(cur), 64'(exp));
          if (v.poke && k == 0 && idx == 1 && !stalled) begin
            start = 1'b1;
            pic_w_ctb = 7'd3;
            pic_h_ctb = 7'd3;
          end
          rdy = v.stall ? ($urandom_range(0, 3) != 0) : 1'b1;
          bus.tu_ready = rdy;
          stalled = !rdy;
          snap = cur;
          if (rdy) begin
            idx++;
            got++;
          end
        end
        @(negedge clk);
        start = 1'b0;
        bus.tu_ready = 1'b1;
        cyc++;
      end
      if (idx < n) chk("ctb_timeout", 64'(idx), 64'(n));
    end
    chk("tu_total", 64'(got), 64'(v.total));
    chk("done_pulse", 64'(done), 64'd1);
    chk("idle_cfg_ready", 64'(bus.cfg_ready), 64'd0);
    chk("idle_valid", 64'(bus.tu_valid), 64'd0);
    @(negedge clk);
    chk("done_single", 64'(done), 64'd0);
  endtask

  initial begin
    vecs[0] = '{w:7'd1, h:7'd1, ncfg:3'd1, sz:{3'd0,3'd0,3'd0,3'd5}, l2:{3'd0,3'd0,3'd0,3'd5},
                total:16'd4,   stall:1'b0, poke:1'b0};
    vecs[1] = '{w:7'd2, h:7'd1, ncfg:3'd2, sz:{3'd0,3'd0,3'd2,3'd4}, l2:{3'd0,3'd0,3'd2,3'd4},
                total:16'd272, stall:1'b0, poke:1'b0};
    vecs[2] = '{w:7'd2, h:7'd1, ncfg:3'd2, sz:{3'd0,3'd0,3'd0,3'd7}, l2:{3'd0,3'd0,3'd2,3'd5},
                total:16'd260, stall:1'b0, poke:1'b0};
    vecs[3] = '{w:7'd0, h:7'd0, ncfg:3'd1, sz:{3'd0,3'd0,3'd0,3'd3}, l2:{3'd0,3'd0,3'd0,3'd3},
                total:16'd64,  stall:1'b1, poke:1'b1};
    vecs[4] = '{w:7'd1, h:7'd2, ncfg:3'd2, sz:{3'd0,3'd0,3'd5,3'd3}, l2:{3'd0,3'd0,3'd5,3'd3},
                total:16'd68,  stall:1'b1, poke:1'b0};
    vecs[5] = '{w:7'd2, h:7'd2, ncfg:3'd4, sz:{3'd5,3'd1,3'd5,3'd6}, l2:{3'd5,3'd2,3'd5,3'd5},
                total:16'd268, stall:1'b0, poke:1'b0};

    bus.cfg_valid  = 1'b0;
    bus.cfg_tuSize = '0;
    bus.tu_ready   = 1'b1;

    repeat (2) @(negedge clk);
    chk("reset_outputs", 64'(out_word()), 64'd0);
    chk("reset_cfg_ready", 64'(bus.cfg_ready), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    arst_n = 1'b1;
    @(negedge clk);

    for (int unsigned i = 0; i < 6; i++) run_pic(vecs[i]);

    // Abort in the middle of the second CTB of a 2x1 picture.
    pic_w_ctb = 7'd2;
    pic_h_ctb = 7'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bus.cfg_valid  = 1'b1;
    bus.cfg_tuSize = 3'd5;
    @(negedge clk);
    bus.cfg_valid = 1'b0;
    repeat (4) @(negedge clk);
    bus.cfg_valid = 1'b1;
    @(negedge clk);
    bus.cfg_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_ctb_x", 64'(bus.xCtb), 64'd4);
    chk("mid_ctb_valid", 64'(bus.tu_valid), 64'd1);
    #2 arst_n = 1'b0;
    #1;
    chk("abort_outputs", 64'(out_word()), 64'd0);
    chk("abort_cfg_ready", 64'(bus.cfg_ready), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    @(negedge clk);
    arst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_abort_idle", 64'({done, bus.cfg_ready, bus.tu_valid}), 64'd0);
    end

    run_pic(vecs[1]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
